// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared FSM state type and index-width helper for seq_chunk_adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic int idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple adder built from full-adder equations.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit adder, CHUNK bits per clock through a registered carry.
// Define SEQ_CHUNK_ADDER_ADDSUB_EN to add a sub port (result becomes a + ~b + cin).
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = idx_width(NCH);

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b, b_eff;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] cs;
    logic             co, cm;
    int               base;

`ifdef SEQ_CHUNK_ADDER_ADDSUB_EN
    assign b_eff = sub ? ~b : b;
`else
    assign b_eff = b;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign base      = int'(idx) * CHUNK;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a    (op_a[base +: CHUNK]),
        .b    (op_b[base +: CHUNK]),
        .cin  (carry),
        .s    (cs),
        .cout (co),
        .cmsb (cm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_a  <= a;
                    op_b  <= b_eff;
                    carry <= cin;
                    idx   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    sum[base +: CHUNK] <= cs;
                    carry              <= co;
                    // idx holds at the last chunk so it never wraps
                    if (idx == IW'(NCH - 1)) begin
                        cout  <= co;
                        ovf   <= co ^ cm;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed and random checks of seq_chunk_adder (WIDTH=32, CHUNK=4).
module tb_seq_chunk_adder;

    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_assert = 0;
    int n_fail   = 0;

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SEQ_CHUNK_ADDER_ADDSUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: {cout,sum} is the plain 33-bit sum; overflow when same-sign operands give a different-sign result.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc, input int hold);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] es;
        logic             ec, eo;
        int               cnt;
        full = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
        es   = full[WIDTH-1:0];
        ec   = full[WIDTH];
        eo   = (ta[WIDTH-1] == tb[WIDTH-1]) && (es[WIDTH-1] != ta[WIDTH-1]);
        @(negedge clk);
        chk1("in_ready_idle", in_ready, 1'b1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk1("in_ready_busy", in_ready, 1'b0);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk("latency", cnt, NCH);
        chk1("out_valid", out_valid, 1'b1);
        chk("sum", sum, es);
        chk1("cout", cout, ec);
        chk1("ovf", ovf, eo);
        chk1("in_ready_done", in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_sum", sum, es);
            chk1("hold_cout", cout, ec);
            chk1("hold_ovf", ovf, eo);
            chk1("hold_valid", out_valid, 1'b1);
            chk1("hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk1("after_hs_valid", out_valid, 1'b0);
        chk1("after_hs_ready", in_ready, 1'b1);
    endtask

    initial begin
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, '0);
        chk1("rst_cout", cout, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1);
        run_op($urandom, $urandom, 1'b1, 5);

        // Abort an operation at chunk index 3
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk("abort_sum", sum, '0);
        chk1("abort_cout", cout, 1'b0);
        chk1("abort_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0);

        for (int k = 0; k < 20; k++)
            run_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
